// File: rtl/ifu_pcgen_pkg.sv
// Shared constants and types for the instruction-fetch PC generator.
// Fetch address-bus and instruction-bus widths, reset PC and instruction size.
package ifu_pcgen_pkg;

  localparam int unsigned MYRISCV_ADDRBUS = 32;
  localparam int unsigned MYRISCV_INSTBUS = 32;
  localparam logic [MYRISCV_ADDRBUS-1:0] IFU_RESET_PC = 32'h8000_0000;
  localparam int unsigned IFU_INSN_BYTES = 4;

  typedef enum logic [1:0] {
    ADDR_SEQ,
    ADDR_BPU,
    ADDR_FLUSH
  } addr_src_e;

  // A pending execute redirect always wins over a fresh prediction.
  function automatic addr_src_e pick_src(input logic flush_pend, input logic taken);
    if (flush_pend) return ADDR_FLUSH;
    if (taken) return ADDR_BPU;
    return ADDR_SEQ;
  endfunction

endpackage

// File: rtl/ifu_pcgen_pc_tag_fifo.sv
// Synchronous FIFO holding the PC of each issued fetch until its response returns.
// A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
module pc_tag_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_pcgen.sv
// Fetch-address generator and in-order PC tagger feeding newbpu.
// Redirects on execute flush (priority) or registered taken prediction (op1+op2).
module ifu_pcgen
  import ifu_pcgen_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = IFU_RESET_PC,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_flush_i,
  input  logic [31:0] ex_flush_pc_i,
  input  logic        bpu_taken_r_i,
  input  logic [31:0] bpu_jump_op1_i,
  input  logic [31:0] bpu_jump_op2_i,
  output logic        pc_req_vld_o,
  input  logic        pc_req_rdy_i,
  output logic [31:0] pc_req_addr_o,
  input  logic        mem_rsp_vld_i,
  input  logic [31:0] mem_rsp_ins_i,
  output logic        mem_rsp_rdy_o,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_pc_o,
  output logic [31:0] rsp_ins_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0] pc_q;
  logic [31:0] flush_pc_q;
  logic        flush_pend;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop_cnt;

  addr_src_e   src;
  logic        req_fire;
  logic        rsp_fire;
  logic        rsp_legal;
  logic        dropping;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] fifo_head;

  always_comb begin
    src = pick_src(flush_pend, bpu_taken_r_i);
    pc_req_addr_o = pc_q;
    unique case (src)
      ADDR_FLUSH: pc_req_addr_o = flush_pc_q;
      ADDR_BPU:   pc_req_addr_o = bpu_jump_op1_i + bpu_jump_op2_i;
      default:    pc_req_addr_o = pc_q;
    endcase
  end

  assign pc_req_vld_o = ~rst & ~ex_flush_i & (outst < CW'(MAX_OUTSTANDING)) & ~fifo_full;
  assign req_fire     = pc_req_vld_o & pc_req_rdy_i;

  // A response with nothing outstanding is swallowed without touching the tag FIFO.
  assign rsp_legal     = ~fifo_empty;
  assign dropping      = ex_flush_i | (drop_cnt != '0);
  assign mem_rsp_rdy_o = rst | dropping | ~rsp_legal | rsp_rdy_i;
  assign rsp_vld_o     = ~rst & mem_rsp_vld_i & ~dropping & rsp_legal;
  assign rsp_fire      = mem_rsp_vld_i & mem_rsp_rdy_o & rsp_legal;
  assign rsp_pc_o      = fifo_head;
  assign rsp_ins_o     = mem_rsp_ins_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      flush_pend <= 1'b0;
      flush_pc_q <= '0;
      outst      <= '0;
      drop_cnt   <= '0;
    end else begin
      if (req_fire) begin
        pc_q       <= pc_req_addr_o + 32'(IFU_INSN_BYTES);
        flush_pend <= 1'b0;
      end
      if (ex_flush_i) begin
        flush_pend <= 1'b1;
        flush_pc_q <= ex_flush_pc_i;
        drop_cnt   <= outst - CW'(rsp_fire);
      end else if (rsp_fire && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      outst <= outst + CW'(req_fire) - CW'(rsp_fire);
    end
  end

  pc_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (32)
  ) u_pc_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc_req_addr_o),
    .pop       (rsp_fire),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: doc/ifu_pcgen.md
Name: ifu_pcgen

Overview:
- Fetch-address generator plus in-order response tagger, directly upstream of newbpu.
- Issues instruction-fetch requests to instruction memory and tags each returned instruction with its PC.
- Forwards the tagged instruction to newbpu as bpu_pc/bpu_ins/pc_rsp_vld.
- Redirects on an execute flush, or on newbpu's registered taken prediction using target op1+op2.

Parameters:
- RESET_PC, 32'h8000_0000, address of the first fetch after reset.
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered requests; power of two, at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- ex_flush_i  in  1  execute-stage redirect pulse.
- ex_flush_pc_i  in  32  redirect target.
- bpu_taken_r_i  in  1  newbpu registered prediction (bpu_prdt_taken_r_o).
- bpu_jump_op1_i  in  32  predicted target operand 1.
- bpu_jump_op2_i  in  32  predicted target operand 2.
- pc_req_vld_o  out  1  fetch request valid; also drives newbpu pc_req_vld_mi.
- pc_req_rdy_i  in  1  memory accepts request; also drives newbpu pc_req_rdy_mi.
- pc_req_addr_o  out  32  fetch address.
- mem_rsp_vld_i  in  1  memory response valid, in order.
- mem_rsp_ins_i  in  32  fetched instruction.
- mem_rsp_rdy_o  out  1  ready to memory.
- rsp_vld_o  out  1  to newbpu pc_rsp_vld_i.
- rsp_rdy_i  in  1  from newbpu pc_rsp_rdy_i.
- rsp_pc_o  out  32  PC of the current response (bpu_pc_i).
- rsp_ins_o  out  32  instruction of the current response (bpu_ins_i).

Behaviour:
- State registers:
  - pc_q: next sequential address.
  - flush_pend, flush_pc_q: pending flush and its target.
  - outst: count of outstanding requests, 0..MAX_OUTSTANDING.
  - drop_cnt: count of in-flight responses to discard.
  - PC tag FIFO.
- Reset values: pc_q=RESET_PC, flush_pend=0, outst=0, drop_cnt=0, FIFO empty.
- Reset outputs: pc_req_vld_o=0, rsp_vld_o=0, mem_rsp_rdy_o=1.
- Request address (combinational), highest priority first:
  - flush_pend: flush_pc_q.
  - bpu_taken_r_i: (op1+op2) mod 2^32.
  - otherwise: pc_q.
- pc_req_vld_o = ~rst & ~ex_flush_i & (outst < MAX_OUTSTANDING).
  - The first request is presented in the first cycle after rst deasserts.
  - Address may change while vld&~rdy only because of a flush or a bpu_taken_r_i rise. The memory contract permits this; a request is not committed until its handshake.
- Request handshake (vld & rdy), same edge:
  - pc_q <= addr+4.
  - flush_pend <= 0.
  - push addr into the FIFO.
  - outst += 1.
- newbpu clears taken_r on the same handshake, so a prediction redirects exactly one request.
- ex_flush_i cycle:
  - flush_pend <= 1 and flush_pc_q <= ex_flush_pc_i.
  - No request in this cycle.
  - drop_cnt <= outst - (mem response handshake this cycle).
  - A second flush overwrites the pending target.
- dropping = ex_flush_i | (drop_cnt != 0).
- Response path (combinational):
  - rsp_vld_o = mem_rsp_vld_i & ~dropping.
  - mem_rsp_rdy_o = dropping ? 1 : rsp_rdy_i.
  - rsp_pc_o = FIFO head; rsp_ins_o = mem_rsp_ins_i.
- Memory response handshake:
  - pop the FIFO and decrement outst.
  - If dropping and no flush this cycle, decrement drop_cnt.
- Request and response handshakes in the same cycle: outst unchanged, FIFO pushes and pops together.
  - At the limit (outst == MAX_OUTSTANDING), a pop does not enable a same-cycle push: vld is computed from registered outst.
- Wrong-path discard after a taken branch is newbpu's job (it holds rdy high while taken_r). This block does not drop those responses.
- A response while outst==0 is a protocol violation: ignored, mem_rsp_rdy_o=1, FIFO unchanged. The bench flags it with an assertion.
- rst mid-operation: all state returns to reset values within one cycle; in-flight responses arriving after reset count as violations. The memory is reset together with this block.

Decomposition:
- mydefines.v supplies MYRISCV_ADDRBUS, MYRISCV_INSTBUS and RSTLEVEL.
- Add to mydefines.v: IFU_RESET_PC and IFU_INSN_BYTES=4.
- Sub-module pc_tag_fifo: synchronous FIFO, depth MAX_OUTSTANDING, width 32, ports push/pop/head/full/empty. Also reused by the future fetch buffer.

Test Plan:
- Reset release, memory always ready with 1-cycle latency: requests issue at 8000_0000, 8000_0004, 8000_0008; rsp_pc_o matches each instruction.
- Memory rdy low for 3 cycles: vld held, address stays 8000_0000, no duplicate push; outst never exceeds 2.
- bpu_taken_r_i=1 with op1=8000_0010 and op2=0000_0020: next request addr 8000_0030, following request 8000_0034.
- ex_flush_i to 8000_1000 with 2 outstanding: both old responses consumed with rsp_vld_o=0; first forwarded response has rsp_pc_o=8000_1000.
- Flush coinciding with a response handshake and with bpu_taken_r_i=1: that response dropped, drop_cnt=1, next request addr = flush target, not op1+op2.
- rst asserted with outst=2: next cycle outst=0, FIFO empty; first request after release is RESET_PC.
